// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_stage
//  Purpose  : Instruction fetch stage of a 5-stage RISC-V pipeline. Holds the
//             program counter, drives the word address into a combinational
//             instruction memory, and registers the returned instruction and
//             its PC into the IF/ID pipeline register. Supports hazard stalls
//             and branch redirects with bubble insertion.
//  Ports    : clk, reset (sync, active-high)
//             stall, redirect, redirect_target  - control from downstream
//             imem_addr (word index) / imem_instr - instruction memory
//             pc                                - current fetch PC
//             if_pc, if_instr, if_valid         - IF/ID register
//             if_misalign                       - only with IF_MISALIGN_TRAP_EN
//  Config   : `define IF_MISALIGN_TRAP_EN to report misaligned redirect
//             targets through if_misalign instead of silently aligning them.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        if_misalign
`endif
);

    localparam logic [31:0] c_PC_STEP    = 32'd4;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_if_valid;

    // Redirect target with the byte-offset bits dropped; the PC always holds
    // a word-aligned address.
    logic [31:0] w_target_aligned;
    assign w_target_aligned = redirect_target & c_ALIGN_MASK;

`ifdef IF_MISALIGN_TRAP_EN
    logic r_if_misalign;
    logic w_target_misaligned;
    assign w_target_misaligned = (redirect_target[1:0] != 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_if_pc    <= 32'h0000_0000;
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            r_if_misalign <= 1'b0;
`endif
        end else if (redirect) begin
            // The instruction fetched this cycle is on the wrong path: drop it
            // and insert a bubble. Redirect wins over a simultaneous stall.
            r_pc       <= w_target_aligned;
            r_if_pc    <= 32'h0000_0000;
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            // A misaligned target travels down the pipe as a marked bubble
            // carrying the original (unaligned) address for the trap handler.
            r_if_misalign <= w_target_misaligned;
            if (w_target_misaligned) begin
                r_if_pc <= redirect_target;
            end
`endif
        end else if (!stall) begin
            r_pc       <= r_pc + c_PC_STEP;
            r_if_pc    <= r_pc;
            r_if_instr <= imem_instr;
            r_if_valid <= 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
            r_if_misalign <= 1'b0;
`endif
        end
        // stall alone: everything holds
    end

    // Word index only depends on the PC register, never on control inputs.
    assign imem_addr = {2'b00, r_pc[31:2]};
    assign pc        = r_pc;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign if_valid  = r_if_valid;
`ifdef IF_MISALIGN_TRAP_EN
    assign if_misalign = r_if_misalign;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_stage
//  Purpose  : Self-checking bench for instr_fetch_stage. A behavioural model
//             tracks the fetch PC and IF/ID contents; a compare process checks
//             every DUT output against it on each falling edge, and directed
//             literal checks pin the model to hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_stage;

    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] c_NOP       = 32'h0000_0013;
`ifdef IF_MISALIGN_TRAP_EN
    localparam bit          c_MIS_EN    = 1'b1;
`else
    localparam bit          c_MIS_EN    = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        if_misalign;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [31:0] m_pc;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_instr;
    logic        m_if_valid;
    logic        m_if_mis;

    instr_fetch_stage #(
        .RESET_PC  (c_RESET_PC),
        .NOP_INSTR (c_NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .pc              (pc),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_valid        (if_valid)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .if_misalign     (if_misalign)
`endif
    );

`ifndef IF_MISALIGN_TRAP_EN
    assign if_misalign = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a function of the word index.
    function automatic logic [31:0] memf(input logic [31:0] w);
        case (w)
            32'd0:   memf = 32'h003100B3;
            32'd1:   memf = 32'h40628233;
            default: memf = {w[15:0], ~w[15:0]} ^ 32'h5A5A_0000 ^ {2'b00, w[31:2]};
        endcase
    endfunction

    assign imem_instr = memf(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: one clock edge given the inputs applied before it.
    task automatic model_edge(input logic r, input logic s, input logic rd,
                              input logic [31:0] t);
        if (r) begin
            m_pc = c_RESET_PC; m_if_pc = 0; m_if_instr = c_NOP;
            m_if_valid = 0; m_if_mis = 0;
        end else if (rd) begin
            m_pc = {t[31:2], 2'b00};
            m_if_instr = c_NOP;
            m_if_valid = 0;
            if (c_MIS_EN && t[1:0] != 2'b00) begin
                m_if_pc = t; m_if_mis = 1;
            end else begin
                m_if_pc = 0; m_if_mis = 0;
            end
        end else if (!s) begin
            m_if_pc = m_pc;
            m_if_instr = memf(m_pc / 4);
            m_if_valid = 1;
            m_if_mis = 0;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [31:0] t);
        reset = r; stall = s; redirect = rd; redirect_target = t;
        @(posedge clk);
        model_edge(r, s, rd, t);
        @(negedge clk);
    endtask

    // Compare process: every output against the model each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc",        pc,               m_pc);
            chk("imem_addr", imem_addr,        m_pc / 4);
            chk("if_pc",     if_pc,            m_if_pc);
            chk("if_instr",  if_instr,         m_if_instr);
            chk("if_valid",  {31'd0, if_valid}, {31'd0, m_if_valid});
            chk("if_mis",    {31'd0, if_misalign}, {31'd0, m_if_mis});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; stall = 0; redirect = 0; redirect_target = 0;
        @(negedge clk);
        step(1, 0, 0, 0);
        chk_en = 1'b1;
        step(1, 1, 1, 32'h0000_0040);
        chk("rst pc", pc, 32'h0);
        chk("rst valid", {31'd0, if_valid}, 32'd0);
        chk("rst instr", if_instr, 32'h0000_0013);

        // First fetches
        step(0, 0, 0, 0);
        chk("f0 instr", if_instr, 32'h003100B3);
        chk("f0 if_pc", if_pc, 32'h0);
        chk("f0 pc", pc, 32'h4);
        step(0, 0, 0, 0);
        chk("f1 instr", if_instr, 32'h40628233);
        chk("f1 if_pc", if_pc, 32'h4);

        // Stall three cycles at pc=8
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'h0000_0100);
            chk("stl pc", pc, 32'h8);
            chk("stl addr", imem_addr, 32'h2);
            chk("stl if_pc", if_pc, 32'h4);
            chk("stl valid", {31'd0, if_valid}, 32'd1);
        end
        step(0, 0, 0, 0);
        chk("rel if_pc", if_pc, 32'h8);
        chk("rel pc", pc, 32'hC);

        // Redirect with simultaneous stall at pc=12
        step(0, 1, 1, 32'h0000_0018);
        chk("rd pc", pc, 32'h18);
        chk("rd valid", {31'd0, if_valid}, 32'd0);
        chk("rd instr", if_instr, 32'h0000_0013);
        step(0, 0, 0, 0);
        chk("rd1 if_pc", if_pc, 32'h18);
        chk("rd1 valid", {31'd0, if_valid}, 32'd1);

        // Wrap-around
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap pc", pc, 32'h0);
        chk("wrap addr", imem_addr, 32'h0);
        chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);

        // Redirect to current pc (pc=4 here)
        step(0, 0, 1, 32'h0000_0004);
        chk("self pc", pc, 32'h4);
        chk("self valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 0);

        // Misaligned redirect
        step(0, 0, 1, 32'h0000_0022);
        chk("mis pc", pc, 32'h20);
        chk("mis valid", {31'd0, if_valid}, 32'd0);
        chk("mis if_pc", if_pc, c_MIS_EN ? 32'h22 : 32'h0);
        chk("mis flag", {31'd0, if_misalign}, {31'd0, c_MIS_EN});
        step(0, 1, 0, 0);
        chk("mis hold", {31'd0, if_misalign}, {31'd0, c_MIS_EN});
        step(0, 0, 0, 0);
        chk("mis clr", {31'd0, if_misalign}, 32'd0);
        chk("mis next", if_pc, 32'h20);

        // Reset during stall + redirect
        step(0, 0, 0, 0);
        step(1, 1, 1, 32'h0000_0080);
        chk("mrst pc", pc, 32'h0);
        chk("mrst if_pc", if_pc, 32'h0);
        chk("mrst valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("mrst f0", if_instr, 32'h003100B3);

        // Mixed pseudo-random traffic, checked by the compare process
        for (int i = 0; i < 60; i++) begin
            logic [31:0] tg;
            tg = $urandom;
            step(($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 tg);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage of the 5-stage RISC-V pipeline. Holds the program counter and drives the word address into the combinational instruction memory. Registers the returned instruction and its PC into the IF/ID pipeline register. Supports decode/hazard stalls and branch redirects from downstream, with bubble insertion.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address loaded into the PC on reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): bubble instruction placed in IF/ID.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset. Sampled only on a `clk` rising edge.
- `stall`  in  1  hazard stall: holds the PC and IF/ID.
- `redirect`  in  1  taken branch/jump: load a new PC and squash IF/ID.
- `redirect_target`  in  32  byte address of the new PC, valid when `redirect`=1.
- `imem_addr`  out  32  word index to the instruction memory, = {2'b00, pc[31:2]}. Combinational from the PC register.
- `imem_instr`  in  32  instruction word returned combinationally by the memory in the same cycle.
- `pc`  out  32  current fetch PC (byte address), registered.
- `if_pc`  out  32  IF/ID: PC of `if_instr`.
- `if_instr`  out  32  IF/ID: fetched instruction.
- `if_valid`  out  1  IF/ID: 1 = real instruction, 0 = bubble.
- `if_misalign`  out  1  IF/ID: redirect target was misaligned. Present only with `IF_MISALIGN_TRAP_EN`.

## Operation
- State: PC register (32 bits) plus the IF/ID register (`if_pc`, `if_instr`, `if_valid`, and optionally `if_misalign`).
- Per-edge priority: `reset` > `redirect` > `stall` > normal advance.
- **Reset:** `pc`=RESET_PC, `if_pc`=0, `if_instr`=NOP_INSTR, `if_valid`=0, `if_misalign`=0.
- **Normal advance** (`stall`=0, `redirect`=0):
  - IF/ID <= {pc, imem_instr, valid=1}.
  - pc <= pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- **Redirect** (regardless of `stall`):
  - pc <= redirect_target.
  - IF/ID <= bubble: `if_pc`=0, `if_instr`=NOP_INSTR, `if_valid`=0.
  - The instruction fetched this cycle is discarded.
- **Stall only:** pc and IF/ID all hold their values. `imem_addr` stays constant.
- `imem_addr` low bits: `pc[1:0]` are never sent to memory. Memory depth/wrap is the memory's concern; this block emits the full 30-bit word index.
- Redirect with `redirect_target` equal to the current `pc` is legal: the PC is reloaded and IF/ID is still squashed.
- Inputs are don't-care while `reset`=1. No X may propagate to outputs after reset.

## Timing
- Fetch latency: 1 cycle. The instruction at `pc` in cycle N appears on `if_instr` with `if_valid`=1 in cycle N+1.
- First valid instruction: first edge after `reset` deasserts loads IF/ID with mem[RESET_PC>>2]. `if_valid`=0 during the reset-release cycle.
- Redirect penalty: one bubble. Redirect at edge N: `if_valid`=0 after edge N. The target instruction is valid after edge N+1, if not stalled.
- Stall of k cycles: `if_instr`/`if_pc` held for k extra cycles and `if_valid` unchanged.
- Reset asserted mid-stream: takes effect at the next edge, overriding stall/redirect. All outputs go to reset values in that same edge.
- No combinational path from `stall`/`redirect`/`redirect_target` to any output. `imem_addr` depends only on the PC register.

## Configuration
- Macro: `IF_MISALIGN_TRAP_EN`.
- **Defined:**
  - On redirect with `redirect_target[1:0]`≠0, pc <= target with bits [1:0] cleared.
  - Instead of a plain bubble, IF/ID loads `if_pc`=redirect_target (unmodified), `if_instr`=NOP_INSTR, `if_valid`=0, `if_misalign`=1.
  - `if_misalign` clears on the next non-stalled advance or redirect.
- **Undefined:**
  - `redirect_target[1:0]` is silently forced to 0.
  - The `if_misalign` port does not exist.

## Test plan
- Reset with RESET_PC=0 and mem[0]=32'h003100B3, mem[1]=32'h40628233:
  - `pc`=0 and `if_valid`=0 after reset.
  - Next edge: `if_instr`=32'h003100B3, `if_pc`=0, `pc`=4.
  - Following edge: `if_instr`=32'h40628233, `if_pc`=4.
- Hold `stall`=1 for 3 cycles at pc=8 -> `pc`=8, `imem_addr`=2, and IF/ID unchanged for all 3 cycles. Release: `if_pc`=8 on the next edge.
- `redirect`=1, `redirect_target`=32'h0000_0018 at pc=12 (`stall`=1 simultaneously):
  - Next cycle: `pc`=0x18, `if_valid`=0, `if_instr`=32'h0000_0013.
  - Following cycle: `if_pc`=0x18, `if_valid`=1.
- Redirect to 32'hFFFF_FFFC, then advance -> `pc`=32'h0000_0000, `imem_addr`=0; `if_pc`=32'hFFFF_FFFC on the following edge.
- Assert `reset` during a stall with a simultaneous redirect -> all outputs at reset values after that edge; normal fetch from RESET_PC after release.
- With `IF_MISALIGN_TRAP_EN`, redirect to 32'h0000_0022 -> `pc`=0x20, `if_misalign`=1, `if_pc`=0x22, `if_valid`=0. Without the macro: `pc`=0x20 and a plain bubble.
